// File: rtl/regfile_mp_sb_pkg.sv
// Shared types and defaults for the multi-port register file with busy scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining BYPASS_EN.
package regfile_pkg;

    typedef enum logic [1:0] {S_IDLE, S_SCRUB, S_DONE} scrub_state_t;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;

    function automatic int addr_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Bundle between issue/writeback (master) and the register file (slave).
// Instantiate with the same DATA_W/NUM_REGS/NUM_RD as the regfile_mp_sb it connects to.
interface regfile_mp_sb_if
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = 2
);
    localparam int AW = addr_w(NUM_REGS);

    // Handshake: wr_en/alloc_en/clear_req are one-cycle valids with no ready;
    // any valid presented while scrub_busy or scrub_done is high is dropped, not held.
    logic [NUM_RD-1:0][AW-1:0]     rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]             rd_busy;
    logic                          wr_en;
    logic [AW-1:0]                 wr_addr;
    logic [DATA_W-1:0]             wr_data;
    logic                          alloc_en;
    logic [AW-1:0]                 alloc_addr;
    logic                          clear_req;
    logic                          scrub_busy;
    logic                          scrub_done;
    scrub_state_t                  dbg_state;
    logic [AW-1:0]                 dbg_idx;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, clear_req,
        input  rd_data, rd_busy, scrub_busy, scrub_done, dbg_state, dbg_idx
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, clear_req,
        output rd_data, rd_busy, scrub_busy, scrub_done, dbg_state, dbg_idx
    );

endinterface

// File: rtl/regfile_mp_sb_scrub_fsm.sv
// Soft-clear sequencer: walks every register index once, then pulses done.
// Optional BYPASS_EN lives in the top; this block is unaffected by it.
module regfile_scrub_fsm
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int AW       = addr_w(DEF_NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_req_i,
    output logic          scrub_we_o,
    output logic [AW-1:0] scrub_idx_o,
    output logic          scrub_busy_o,
    output logic          scrub_done_o,
    output scrub_state_t  state_o
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

    scrub_state_t  state_q;
    logic [AW-1:0] idx_q;
    logic          busy_q;
    logic          done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (clear_req_i) begin
                        state_q <= S_SCRUB;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_SCRUB: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_DONE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign scrub_we_o   = (state_q == S_SCRUB);
    assign scrub_idx_o  = idx_q;
    assign scrub_busy_o = busy_q;
    assign scrub_done_o = done_q;
    assign state_o      = state_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with per-register busy scoreboard and scrub engine.
// Define BYPASS_EN to forward a same-cycle legal write onto matching read ports.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    regfile_mp_sb_if.slave bus
);

    localparam int AW = addr_w(NUM_REGS);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;

    logic          scrub_we;
    logic [AW-1:0] scrub_idx;
    scrub_state_t  state;
    logic          idle;
    logic          wr_ok;
    logic          alloc_ok;

    logic [NUM_RD-1:0][DATA_W-1:0] rd_data_d;
    logic [NUM_RD-1:0]             rd_busy_d;

    // Out-of-range (non-power-of-2 depth) and hardwired-zero addresses are not storage.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (int'(a) < NUM_REGS) && !(ZERO_REG && (a == '0));
    endfunction

    regfile_scrub_fsm #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_scrub (
        .clk          (clk),
        .rst          (rst),
        .clear_req_i  (bus.clear_req),
        .scrub_we_o   (scrub_we),
        .scrub_idx_o  (scrub_idx),
        .scrub_busy_o (bus.scrub_busy),
        .scrub_done_o (bus.scrub_done),
        .state_o      (state)
    );

    assign idle     = (state == S_IDLE);
    assign wr_ok    = idle && bus.wr_en && addr_ok(bus.wr_addr);
    assign alloc_ok = idle && bus.alloc_en && addr_ok(bus.alloc_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
        end else if (scrub_we) begin
            regs_q[scrub_idx] <= '0;
        end else if (wr_ok) begin
            regs_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Alloc is applied after writeback clear so a new producer on the same edge wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else if (scrub_we) begin
            busy_q[scrub_idx] <= 1'b0;
        end else begin
            if (wr_ok)    busy_q[bus.wr_addr]    <= 1'b0;
            if (alloc_ok) busy_q[bus.alloc_addr] <= 1'b1;
        end
    end

    always_comb begin
        rd_data_d = '0;
        rd_busy_d = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (addr_ok(bus.rd_addr[i])) begin
                rd_data_d[i] = regs_q[bus.rd_addr[i]];
                rd_busy_d[i] = busy_q[bus.rd_addr[i]];
            end
`ifdef BYPASS_EN
            if (wr_ok && (bus.wr_addr == bus.rd_addr[i])) begin
                rd_data_d[i] = bus.wr_data;
                rd_busy_d[i] = 1'b0;
            end
`endif
        end
    end

    assign bus.rd_data   = rd_data_d;
    assign bus.rd_busy   = rd_busy_d;
    assign bus.dbg_state = state;
    assign bus.dbg_idx   = scrub_idx;

endmodule
